param_accum_shift_reg: RTL and testbench
========================================

Name: param_accum_shift_reg

Overview:
- Parametrised serial accumulator shift register. It parallel-loads a WIDTH-bit operand, then shifts it out serially on Sout while capturing serial input Si.
- Shift direction is selectable per transfer. A bit counter ends the transfer after exactly WIDTH shifts and flags Done; the register then holds the accumulated word.
- Sits in the bit-serial datapath between the operand source and the serial adder/accumulator.

Parameters:
- WIDTH, 8, register/operand width in bits (>=2)
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- L  in  1  load request; accepted only when Busy=0
- Load  in  WIDTH  parallel load value
- Dir  in  1  direction, sampled with L: 0 = shift right (LSB first), 1 = shift left (MSB first)
- En  in  1  shift enable; 0 stalls the transfer with state held
- Si  in  1  serial input bit
- Sout  out  1  serial output bit
- Q  out  WIDTH  parallel register contents
- Busy  out  1  transfer in progress
- Done  out  1  one-cycle pulse, transfer complete

Behaviour:
- Clocking and reset:
  - One clock, CLK.
  - Reset is asynchronous and active-low on RST_N.
  - Reset values: Q=0, Sout=0, Busy=0, Done=0, counter=0, latched direction=0, state=IDLE.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE:
  - Busy=0, Done=0.
  - L=1 at a rising edge: Q<=Load, dir_q<=Dir, cnt<=0, next=SHIFT.
  - L=0: hold.
- SHIFT:
  - Busy=1.
  - En=1 with dir_q=0: Q<={Si, Q[WIDTH-1:1]}, cnt<=cnt+1.
  - En=1 with dir_q=1: Q<={Q[WIDTH-2:0], Si}, cnt<=cnt+1.
  - When cnt==WIDTH-1 and En=1, the edge performs the final shift and next=DONE.
  - En=0 holds Q, cnt and state.
  - L is ignored in SHIFT (no restart, no reload).
- DONE:
  - Busy=0, Done=1 for exactly one cycle; Q holds the final word.
  - L=1 in DONE is accepted as in IDLE (back-to-back transfer): next=SHIFT, and Done is still 1 in that DONE cycle.
  - Otherwise next=IDLE.
- Sout is combinational from the register: Q[0] when dir_q=0, Q[WIDTH-1] when dir_q=1. It is valid from the cycle after load.
- Latency: load to Done = WIDTH + 1 cycles when En is held high. Each En=0 cycle adds one cycle.
- Counter never exceeds WIDTH-1 and never wraps; it resets to 0 on every accepted load.
- Dir changes during SHIFT have no effect; only dir_q is used.
- RST_N asserted mid-transfer aborts immediately to reset values. Deassertion returns to IDLE and requires a new L.

Optional Feature:
- Macro: ACCSR_ROTATE_EN.
- Defined:
  - Adds input port Rot (1 bit, sampled with L, latched as rot_q).
  - With rot_q=1, the bit shifted in is the bit shifted out (Q[0] right, Q[WIDTH-1] left) instead of Si.
  - After WIDTH shifts Q equals the loaded value.
  - Done/Busy timing is unchanged.
- Undefined: no Rot port; the shift-in bit is always Si.

Decomposition:
- Shared package (capstone_pkg):
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Direction constants DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
- One natural sub-module, accsr_bit_counter: CNT_W-bit counter with clear, increment enable and terminal flag (cnt==WIDTH-1). Everything else stays in the top module.

Test Plan:
- WIDTH=8, reset then L=1, Load=8'b10100100, Dir=0, Si=1, En=1 -> Sout at load and after each of the first 7 shifts = 0,0,1,0,0,1,0,1; Q=8'b11111111 with Done=1 exactly 9 cycles after load; Busy=1 for cycles 1-8.
- Load=8'b10100100, Dir=1, Si=0 -> Sout after load, MSB-first = 1,0,1,0,0,1,0,0; final Q=8'h00; Done one cycle.
- Transfer with En=0 for 3 cycles after shift 4 -> Q, Sout and cnt frozen during the stall; Done arrives at load+12; L=1 during SHIFT with Load=8'hFF has no effect.
- L=1 held through the DONE cycle with Load=8'h0F -> Done=1 and reload happen on the same edge; second transfer runs with no IDLE gap.
- RST_N pulled low (asynchronous, between edges) at shift 5 -> Q=0, Busy=0, Done=0 immediately; no Done pulse after release.
- ACCSR_ROTATE_EN defined, Rot=1, Load=8'hA5, Dir=0, Si=1 -> Sout sequence 1,0,1,0,0,1,0,1; final Q=8'hA5.

Source files
------------

// File: rtl/capstone_pkg.sv
// Shared constants for the serial accumulator shift register slice.
package capstone_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } accsr_state_t;

endpackage

// File: rtl/accsr_bit_counter.sv
// Shift counter for one transfer. Clears on load, counts accepted shifts,
// and saturates at WIDTH-1, where tc flags the final shift of the word.
module accsr_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_W'(WIDTH - 1));

  // Count shifts; hold at the terminal value so the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/param_accum_shift_reg.sv
// Parallel-load, serial-shift accumulator register for the bit-serial datapath.
// Optional build macro: ACCSR_ROTATE_EN adds the rot input, which recirculates
// the outgoing bit instead of taking si.
//
// state   | meaning
// --------+------------------------------------------------------
// S_IDLE  | waiting for a load request, busy=0
// S_SHIFT | shifting one bit per enabled cycle, busy=1
// S_DONE  | single-cycle done pulse, a new load may be accepted
module param_accum_shift_reg
  import capstone_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             l,
  input  logic [WIDTH-1:0] load,
  input  logic             dir,
  input  logic             en,
  input  logic             si,
`ifdef ACCSR_ROTATE_EN
  input  logic             rot,
`endif
  output logic             sout,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  accsr_state_t     state;
  logic             dir_q;
  logic             accept;
  logic             shift_fire;
  logic             tc;
  logic             shift_in;
  logic [WIDTH-1:0] shift_nxt;

  assign accept     = l && ((state == S_IDLE) || (state == S_DONE));
  assign shift_fire = (state == S_SHIFT) && en;
  assign sout       = (dir_q == DIR_LEFT) ? q[WIDTH-1] : q[0];

`ifdef ACCSR_ROTATE_EN
  logic rot_q;

  // Latch the rotate mode together with the operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q <= 1'b0;
    end else if (accept) begin
      rot_q <= rot;
    end
  end

  // In rotate mode the outgoing bit re-enters at the other end.
  assign shift_in = rot_q ? sout : si;
`else
  assign shift_in = si;
`endif

  // Next register value for one shift in the latched direction.
  always_comb begin
    shift_nxt = q;
    if (dir_q == DIR_LEFT) begin
      shift_nxt = {q[WIDTH-2:0], shift_in};
    end else begin
      shift_nxt = {shift_in, q[WIDTH-1:1]};
    end
  end

  accsr_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (shift_fire),
    .tc    (tc)
  );

  // Datapath: parallel load on an accepted request, shift on enabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      dir_q <= DIR_RIGHT;
    end else if (accept) begin
      q     <= load;
      dir_q <= dir;
    end else if (shift_fire) begin
      q     <= shift_nxt;
    end
  end

  // Transfer sequencing with registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (l) begin
            state <= S_SHIFT;
            busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (en && tc) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          if (l) begin
            state <= S_SHIFT;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_accum_shift_reg.sv
// Directed bench for param_accum_shift_reg (WIDTH=8). Expected per-cycle
// outputs are queued when inputs are driven and compared at the next negedge.
module tb_param_accum_shift_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       l;
  logic [7:0] load;
  logic       dir;
  logic       en;
  logic       si;
  logic       rot;
  logic       sout;
  logic [7:0] q;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic       sout;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  param_accum_shift_reg #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .l     (l),
    .load  (load),
    .dir   (dir),
    .en    (en),
    .si    (si),
`ifdef ACCSR_ROTATE_EN
    .rot   (rot),
`endif
    .sout  (sout),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Closed-form register contents after k shifts of operand v.
  function automatic logic [7:0] exp_q(input logic [7:0] v, input logic d,
                                       input logic s, input logic r, input int k);
    logic [15:0] w;
    logic [7:0]  fill;
    fill = s ? 8'hFF : 8'h00;
    if (r) begin
      w = {v, v};
      return d ? 8'(w >> (8 - k)) : 8'(w >> k);
    end
    if (d) begin
      w = {v, fill};
      return 8'(w >> (8 - k));
    end
    w = {fill, v};
    return 8'(w >> k);
  endfunction

  task automatic push(input logic s, input logic [7:0] qq, input logic b, input logic dn);
    exp_t e;
    e.sout = s; e.q = qq; e.busy = b; e.done = dn;
    sbq.push_back(e);
  endtask

  task automatic cyc(input string tag);
    exp_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_sout"}, 32'(sout), 32'(e.sout));
      chk({tag, "_q"},    32'(q),    32'(e.q));
      chk({tag, "_busy"}, 32'(busy), 32'(e.busy));
      chk({tag, "_done"}, 32'(done), 32'(e.done));
    end
  endtask

  task automatic idle(input int n, input logic [7:0] qexp, input logic sexp, input string tag);
    for (int i = 0; i < n; i++) begin
      l = 1'b0; en = 1'b1;
      push(sexp, qexp, 1'b0, 1'b0);
      cyc(tag);
    end
  endtask

  // One transfer from the load cycle through the done cycle (or abort point).
  task automatic xfer(input logic [7:0] v, input logic d, input logic s, input logic r,
                      input int stall_at, input int stall_len, input bit poke_l,
                      input int abort_at, input string tag,
                      output logic [7:0] seq, output int lat);
    int k = 0;
    int stalled = 0;
    int cyc_n = 0;
    logic [7:0] eq;
    seq = '0;
    lat = 0;
    l = 1'b1; load = v; dir = d; si = s; en = 1'b1; rot = r;
    eq = exp_q(v, d, s, r, 0);
    push(d ? eq[7] : eq[0], eq, 1'b1, 1'b0);
    cyc(tag);
    cyc_n = 1;
    seq[0] = sout;
    while (k < 8 && cyc_n < 40) begin
      if (abort_at >= 0 && k == abort_at) return;
      l = poke_l; load = 8'hFF; dir = ~d;
      if (k == stall_at && stalled < stall_len) begin
        en = 1'b0;
        stalled++;
      end else begin
        en = 1'b1;
        k++;
      end
      eq = exp_q(v, d, s, r, k);
      push(d ? eq[7] : eq[0], eq, k < 8, k == 8);
      cyc(tag);
      cyc_n++;
      if (k < 8 && en) seq[k] = sout;
      if (done === 1'b1 && lat == 0) lat = cyc_n;
    end
    l = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    logic [7:0] seq;
    int lat;
    rst_n = 1'b0; l = 1'b0; load = '0; dir = 1'b0; en = 1'b0; si = 1'b0; rot = 1'b0;
    #23;
    chk("rst_q",    32'(q),    32'h0);
    chk("rst_sout", 32'(sout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 8'h00, 1'b0, "idle0");

    // Right shift, Si=1: LSB first, fills with ones.
    xfer(8'b10100100, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0, -1, "t1", seq, lat);
    chk("t1_sout_seq", 32'(seq), 32'b10100100);
    chk("t1_final_q",  32'(q),   32'hFF);
    chk("t1_latency",  32'(lat), 32'd9);
    idle(1, 8'hFF, 1'b1, "t1_after");

    // Left shift, Si=0: MSB first, fills with zeros.
    xfer(8'b10100100, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0, -1, "t2", seq, lat);
    chk("t2_sout_seq", 32'(seq), 32'b00100101);
    chk("t2_final_q",  32'(q),   32'h00);
    chk("t2_latency",  32'(lat), 32'd9);
    idle(1, 8'h00, 1'b0, "t2_after");

    // Three-cycle stall after shift 4, with L=1/Load=FF poked during SHIFT.
    xfer(8'h3C, 1'b0, 1'b0, 1'b0, 4, 3, 1'b1, -1, "t3", seq, lat);
    chk("t3_final_q", 32'(q),   32'h00);
    chk("t3_latency", 32'(lat), 32'd12);
    idle(1, 8'h00, 1'b0, "t3_after");

    // Back-to-back: reload accepted in the DONE cycle.
    xfer(8'hC3, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, -1, "t4a", seq, lat);
    chk("t4a_done_at_reload", 32'(done), 32'h1);
    xfer(8'h0F, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, -1, "t4b", seq, lat);
    chk("t4b_sout_seq", 32'(seq), 32'b11110000);
    chk("t4b_final_q",  32'(q),   32'hFF);
    chk("t4b_latency",  32'(lat), 32'd9);
    idle(1, 8'hFF, 1'b1, "t4_after");

    // Asynchronous reset mid-transfer after shift 5.
    xfer(8'h5A, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0, 5, "t5", seq, lat);
    chk("t5_pre_busy", 32'(busy), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_abort_q",    32'(q),    32'h0);
    chk("t5_abort_busy", 32'(busy), 32'h0);
    chk("t5_abort_done", 32'(done), 32'h0);
    chk("t5_abort_sout", 32'(sout), 32'h0);
    chk("t5_sb_empty",   32'(sbq.size()), 32'd0);
    sbq.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    idle(12, 8'h00, 1'b0, "t5_after");

`ifdef ACCSR_ROTATE_EN
    // Rotate: outgoing bit recirculates, word restored after 8 shifts.
    xfer(8'hA5, 1'b0, 1'b1, 1'b1, -1, 0, 1'b0, -1, "t6", seq, lat);
    chk("t6_sout_seq", 32'(seq), 32'b10100101);
    chk("t6_final_q",  32'(q),   32'hA5);
    chk("t6_latency",  32'(lat), 32'd9);
    rot = 1'b0;
    idle(1, 8'hA5, 1'b1, "t6_after");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
